// File: rtl/serial_adder_if.sv
// Handshake and data bundle for serial_adder.
//   start/sub/a/b/cin : request side, driven by the master
//   busy/done         : status, driven by the adder
//   sum/cout/ovf      : result, held until the next completion
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, operands
// consumed LSB-first over WIDTH cycles.
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : serial_adder_if slave port (start/sub/a/b/cin in; busy/done/sum/cout/ovf out)
// Subtraction is a + ~b + 1, so cout=1 means "no borrow".
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  areg_q, areg_d;
  logic [WIDTH-1:0]  breg_q, breg_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic              bit_s;
  logic              carry_nxt;
  logic              accept;
  logic              last_bit;

  // Shared full-adder cell working on the current LSBs.
  assign bit_s     = areg_q[0] ^ breg_q[0] ^ carry_q;
  assign carry_nxt = (areg_q[0] & breg_q[0]) | (areg_q[0] & carry_q) | (breg_q[0] & carry_q);
  assign accept    = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign last_bit  = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: state_d = StIdle;
      StRun: begin
        areg_d  = areg_q >> 1;
        breg_d  = breg_q >> 1;
        carry_d = carry_nxt;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB.
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = carry_nxt;
          ovf_d   = carry_q ^ carry_nxt;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Only possible in StIdle/StDone, so it never disturbs a running operation.
    if (accept) begin
      areg_d  = bus.a;
      breg_d  = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub ? 1'b1 : bus.cin;
      cnt_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      areg_q  <= '0;
      breg_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // StDone lasts exactly one cycle, so done is a single-cycle pulse.
  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one accept edge, then waits (bounded) for done.
  // lat counts cycles after the accept edge; busy_cnt counts busy cycles seen.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, output logic [7:0] s, output logic c,
                       output logic o, output int lat, output int busy_cnt);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = 8'hA5; bus.b = 8'h5A; bus.cin = ~cin; bus.sub = ~sub;
    lat = 0; busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    s = bus.sum; c = bus.cout; o = bus.ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.sub = 1'b0;
    bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== 11'h0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                 i, bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
      end
    end
    rst = 1'b0; bus.start = 1'b0;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stays_idle: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_arith();
    // a, b, cin, sub, sum, cout, ovf (hand-computed)
    logic [7:0] va [6] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h00};
    logic [7:0] vb [6] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01, 8'h00};
    logic       vc [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    logic       vs [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    logic [7:0] es [6] = '{8'h10, 8'h01, 8'h80, 8'hFE, 8'h7F, 8'h01};
    logic       ec [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    logic       eo [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [7:0] s;
    logic       c, o;
    int         lat, bc;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vc[i], vs[i], s, c, o, lat, bc);
      n_tests++;
      if (s !== es[i] || c !== ec[i] || o !== eo[i]) begin
        n_fail++;
        $display("FAIL arith_%0d: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                 i, s, c, o, es[i], ec[i], eo[i]);
      end
      n_tests++;
      if (lat !== 8 || bc !== 8) begin
        n_fail++;
        $display("FAIL timing_%0d: latency=%0d busy_cycles=%0d, want 8 8", i, lat, bc);
      end
      tick();
      n_tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse_%0d: done=%b busy=%b after pulse, want 0 0",
                 i, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_start_mid_run();
    int  t;
    logic changed;
    logic [7:0] old_sum;
    old_sum = bus.sum;
    changed = 1'b0;
    bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t = 0;
    while (bus.done !== 1'b1 && t < 40) begin
      if (t == 3) begin
        bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.sub = 1'b1; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.sum !== old_sum) changed = 1'b1;
      tick();
      t++;
    end
    bus.start = 1'b0;
    n_tests++;
    if (bus.sum !== 8'h33 || bus.cout !== 1'b0 || bus.ovf !== 1'b0 || t !== 8) begin
      n_fail++;
      $display("FAIL start_mid_run: sum=%h cout=%b ovf=%b lat=%0d, want 33 0 0 8",
               bus.sum, bus.cout, bus.ovf, t);
    end
    n_tests++;
    if (changed) begin
      n_fail++;
      $display("FAIL sum_stable: sum changed during RUN, want held at %h", old_sum);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int t, d1, d2;
    logic [7:0] s1, s2;
    logic b_after;
    bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    tick();
    bus.a = 8'h10; bus.b = 8'h20;
    t = 0; d1 = -1; d2 = -1; s1 = '0; s2 = '0; b_after = 1'b0;
    while (d2 < 0 && t < 40) begin
      tick();
      t++;
      if (bus.done === 1'b1) begin
        if (d1 < 0) begin
          d1 = t; s1 = bus.sum;
        end else begin
          d2 = t; s2 = bus.sum;
        end
      end
      if (d1 >= 0 && t == d1 + 1) begin
        bus.start = 1'b0;
        b_after = bus.busy;
      end
    end
    bus.start = 1'b0;
    n_tests++;
    if (d1 !== 8 || d2 !== 17) begin
      n_fail++;
      $display("FAIL b2b_spacing: done at %0d and %0d, want 8 and 17", d1, d2);
    end
    n_tests++;
    if (s1 !== 8'h03 || s2 !== 8'h30) begin
      n_fail++;
      $display("FAIL b2b_results: sums %h %h, want 03 30", s1, s2);
    end
    n_tests++;
    if (b_after !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_busy: busy=%b cycle after first done, want 1", b_after);
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_width: done=%b after second pulse, want 0", bus.done);
    end
  endtask

  task automatic test_reset_mid_run();
    logic saw_done;
    logic [7:0] s;
    logic c, o;
    int lat, bc;
    bus.a = 8'h55; bus.b = 8'h11; bus.cin = 1'b1; bus.sub = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL abort_no_done: activity seen after abort, want none");
    end
    do_op(8'h12, 8'h34, 1'b0, 1'b0, s, c, o, lat, bc);
    n_tests++;
    if (s !== 8'h46 || c !== 1'b0 || o !== 1'b0 || lat !== 8) begin
      n_fail++;
      $display("FAIL after_abort: sum=%h cout=%b ovf=%b lat=%0d, want 46 0 0 8", s, c, o, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, s, es;
    logic       cin, sub, c, o, ec, eo;
    logic [8:0] r;
    int         lat, bc;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      if (sub) begin
        r  = {1'b0, a} + {1'b0, ~b} + 9'd1;
        eo = (a[7] != b[7]) && (r[7] != a[7]);
      end else begin
        r  = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        eo = (a[7] == b[7]) && (r[7] != a[7]);
      end
      es = r[7:0]; ec = r[8];
      do_op(a, b, cin, sub, s, c, o, lat, bc);
      n_tests++;
      if (s !== es || c !== ec || o !== eo || lat !== 8 || bc !== 8) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h cin=%b sub=%b: sum=%h cout=%b ovf=%b lat=%0d busy=%0d, want %h %b %b 8 8",
                 i, a, b, cin, sub, s, c, o, lat, bc, es, ec, eo);
      end
    end
    tick();
  endtask

  initial begin
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    test_reset();
    test_arith();
    test_start_mid_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
